lif_spike_arbiter: RTL and testbench

- Collects per-neuron spike pulses from a LIF layer and serialises them as address-events (AER) on one valid/ready output channel.
- Uses round-robin arbitration so no neuron starves.
- Sits between the LIF neuron array and any downstream consumer: summation stage, output neuron feeder or off-chip port.
- Also sequences timestep boundaries: it reports when all spikes of the current timestep have been handed off.

---
 rtl/lif_pkg.sv | 15 +
 rtl/rr_priority_sel.sv | 28 ++
 rtl/lif_spike_arbiter.sv | 141 ++++++++++++++
 tb/tb_lif_spike_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared LIF-network definitions: default layer size, address-width helper, arbiter states.
package lif_pkg;

  localparam int unsigned LIF_N_NEURONS = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } arb_state_e;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin find-first-set: first set bit at or above ptr_i, wrapping.
module rr_priority_sel #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] pending_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [W-1:0] j;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = '0;
    // Walk from the farthest candidate down so the one nearest ptr_i is written last.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = W'((32'(ptr_i) + 32'(k)) % N);
      if (pending_i[j]) begin
        idx_o   = j;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lif_spike_arbiter.sv
// Round-robin AER serialiser for LIF spikes with timestep flush sequencing.
// Define LIF_ARB_DROP_CNT_EN to add the saturating collision counter port drop_cnt.
module lif_spike_arbiter
  import lif_pkg::*;
#(
  parameter  int unsigned N_NEURONS = LIF_N_NEURONS,
  localparam int unsigned ADDR_W    = addr_w(N_NEURONS)
`ifdef LIF_ARB_DROP_CNT_EN
  ,
  parameter  int unsigned DROP_W    = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 tick,
  output logic                 aer_valid,
  input  logic                 aer_ready,
  output logic [ADDR_W-1:0]    aer_addr,
  output logic                 ts_done,
`ifdef LIF_ARB_DROP_CNT_EN
  output logic [DROP_W-1:0]    drop_cnt,
`endif
  output logic                 busy
);

  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 ts_done_q, ts_done_d;
  logic                 busy_q, busy_d;
  arb_state_e           state_q, state_d;

  logic [N_NEURONS-1:0] clr_mask;
  logic [N_NEURONS-1:0] capture;
  logic [ADDR_W-1:0]    sel_idx;
  logic                 sel_found;
  logic                 load;

  rr_priority_sel #(
    .N (N_NEURONS),
    .W (ADDR_W)
  ) u_sel (
    .pending_i (pending_q),
    .ptr_i     (rr_ptr_q),
    .idx_o     (sel_idx),
    .found_o   (sel_found)
  );

  always_comb begin
    load      = 1'b0;
    clr_mask  = '0;
    capture   = '0;
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    state_d   = state_q;
    ts_done_d = 1'b0;
    busy_d    = 1'b0;

    if (ena) capture = spike_in;

    load = (!valid_q || aer_ready) && sel_found;
    if (load) begin
      clr_mask[sel_idx] = 1'b1;
      addr_d            = sel_idx;
      valid_d           = 1'b1;
      rr_ptr_d          = (sel_idx == ADDR_W'(N_NEURONS - 1)) ? '0 : sel_idx + ADDR_W'(1);
    end else if (aer_ready) begin
      valid_d = 1'b0;
    end

    // A fresh spike on the bit being loaded re-arms it as a new event.
    pending_d = (pending_q & ~clr_mask) | capture;

    unique case (state_q)
      RUN: begin
        if (ena && tick) state_d = FLUSH;
      end
      FLUSH: begin
        if ((pending_q == '0) && !valid_q && (capture == '0)) begin
          ts_done_d = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    busy_d = (pending_d != '0) || valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      ts_done_q <= 1'b0;
      busy_q    <= 1'b0;
      state_q   <= RUN;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      ts_done_q <= ts_done_d;
      busy_q    <= busy_d;
      state_q   <= state_d;
    end
  end

  assign aer_valid = valid_q;
  assign aer_addr  = addr_q;
  assign ts_done   = ts_done_q;
  assign busy      = busy_q;

`ifdef LIF_ARB_DROP_CNT_EN
  logic [DROP_W-1:0]    drop_q, drop_d;
  logic [N_NEURONS-1:0] collide;
  int unsigned          drop_sum;

  // Spikes landing on a still-pending, not-departing bit are merged and counted.
  always_comb begin
    collide  = capture & pending_q & ~clr_mask;
    drop_sum = 32'(drop_q) + 32'($countones(collide));
    drop_d   = (drop_sum > 32'({DROP_W{1'b1}})) ? '1 : DROP_W'(drop_sum);
    if (ts_done_d) drop_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_lif_spike_arbiter.sv
// Directed self-checking bench for lif_spike_arbiter (N_NEURONS = 8).
module tb_lif_spike_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] spike_in = '0;
  logic       tick = 1'b0;
  logic       aer_valid;
  logic       aer_ready = 1'b1;
  logic [2:0] aer_addr;
  logic       ts_done;
  logic       busy;
`ifdef LIF_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  lif_spike_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .tick      (tick),
    .aer_valid (aer_valid),
    .aer_ready (aer_ready),
    .aer_addr  (aer_addr),
    .ts_done   (ts_done),
`ifdef LIF_ARB_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    spike_in  = '0;
    tick      = 1'b0;
    ena       = 1'b1;
    aer_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++; if ({aer_valid, busy, ts_done, aer_addr} !== 6'b0) begin bad++;
      $display("FAIL reset_outs: got v=%b b=%b t=%b a=%0d want all zero", aer_valid, busy, ts_done, aer_addr); end
    step(); step();
    rst_n = 1'b1;
    step();
    total++; if ({aer_valid, busy, ts_done} !== 3'b0) begin bad++;
      $display("FAIL reset_idle: got v=%b b=%b t=%b want 0", aer_valid, busy, ts_done); end
  endtask

  task automatic test_burst();
    apply_reset();
    spike_in = 8'hFF; step(); spike_in = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (aer_valid !== 1'b1 || aer_addr !== 3'(i)) begin bad++;
        $display("FAIL burst_ff[%0d]: got v=%b a=%0d want v=1 a=%0d", i, aer_valid, aer_addr, i); end
    end
    step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL burst_ff_end: got v=%b b=%b want 0 0", aer_valid, busy); end
    spike_in = 8'h81; step(); spike_in = '0;
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd0) begin bad++;
      $display("FAIL burst_81_first: got v=%b a=%0d want v=1 a=0", aer_valid, aer_addr); end
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd7) begin bad++;
      $display("FAIL burst_81_second: got v=%b a=%0d want v=1 a=7", aer_valid, aer_addr); end
    step();
    total++; if (aer_valid !== 1'b0) begin bad++;
      $display("FAIL burst_81_end: got v=%b want 0", aer_valid); end
  endtask

  task automatic test_single();
    apply_reset();
    spike_in = 8'b0000_0100; step(); spike_in = '0;
    total++; if (aer_valid !== 1'b0 || busy !== 1'b1) begin bad++;
      $display("FAIL single_latency: got v=%b b=%b want v=0 b=1", aer_valid, busy); end
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd2) begin bad++;
      $display("FAIL single_event: got v=%b a=%0d want v=1 a=2", aer_valid, aer_addr); end
    step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL single_drain: got v=%b b=%b want 0 0", aer_valid, busy); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    aer_ready = 1'b0;
    spike_in = 8'h0A; step(); spike_in = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd1 || busy !== 1'b1) begin bad++;
        $display("FAIL bp_hold[%0d]: got v=%b a=%0d b=%b want v=1 a=1 b=1", i, aer_valid, aer_addr, busy); end
    end
    aer_ready = 1'b1;
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd3) begin bad++;
      $display("FAIL bp_second: got v=%b a=%0d want v=1 a=3", aer_valid, aer_addr); end
    step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL bp_drain: got v=%b b=%b want 0 0", aer_valid, busy); end
  endtask

  task automatic test_collision();
    apply_reset();
    aer_ready = 1'b0;
    spike_in = 8'h01; step();
    spike_in = '0; step();
    spike_in = 8'h20; step();
    spike_in = 8'h20; step();
    spike_in = '0;
`ifdef LIF_ARB_DROP_CNT_EN
    total++; if (drop_cnt !== 8'd1) begin bad++;
      $display("FAIL coll_drop_cnt: got %0d want 1", drop_cnt); end
`endif
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd0) begin bad++;
      $display("FAIL coll_hold: got v=%b a=%0d want v=1 a=0", aer_valid, aer_addr); end
    aer_ready = 1'b1;
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd5) begin bad++;
      $display("FAIL coll_event5: got v=%b a=%0d want v=1 a=5", aer_valid, aer_addr); end
    step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL coll_merged: got v=%b b=%b want 0 0", aer_valid, busy); end

    // Re-arm: the bit is set again on the cycle its event is loaded.
    apply_reset();
    spike_in = 8'h20; step();
    spike_in = 8'h20; step();
    spike_in = '0;
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd5) begin bad++;
      $display("FAIL rearm_first: got v=%b a=%0d want v=1 a=5", aer_valid, aer_addr); end
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd5) begin bad++;
      $display("FAIL rearm_second: got v=%b a=%0d want v=1 a=5", aer_valid, aer_addr); end
    step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL rearm_drain: got v=%b b=%b want 0 0", aer_valid, busy); end
`ifdef LIF_ARB_DROP_CNT_EN
    total++; if (drop_cnt !== 8'd0) begin bad++;
      $display("FAIL rearm_drop_cnt: got %0d want 0", drop_cnt); end
`endif
  endtask

  task automatic test_timestep();
    apply_reset();
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_empty_early: got %b want 0", ts_done); end
    step();
    total++; if (ts_done !== 1'b1) begin bad++;
      $display("FAIL ts_empty_pulse: got %b want 1", ts_done); end
    step();
    total++; if (ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_empty_single: got %b want 0", ts_done); end

    // Three pending events (0,1,4), plus a second tick during FLUSH.
    apply_reset();
    spike_in = 8'h13; step(); spike_in = '0;
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd0 || ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_ev0: got v=%b a=%0d t=%b want v=1 a=0 t=0", aer_valid, aer_addr, ts_done); end
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (aer_addr !== 3'd1 || ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_ev1: got a=%0d t=%b want a=1 t=0", aer_addr, ts_done); end
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd4 || ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_ev4: got v=%b a=%0d t=%b want v=1 a=4 t=0", aer_valid, aer_addr, ts_done); end
    step();
    total++; if (aer_valid !== 1'b0 || ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_accepted: got v=%b t=%b want 0 0", aer_valid, ts_done); end
    step();
    total++; if (ts_done !== 1'b1) begin bad++;
      $display("FAIL ts_flush_pulse: got %b want 1", ts_done); end
    step();
    total++; if (ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_flush_after1: got %b want 0", ts_done); end
    step();
    total++; if (ts_done !== 1'b0) begin bad++;
      $display("FAIL ts_flush_after2: got %b want 0", ts_done); end
  endtask

  task automatic test_enable();
    apply_reset();
    ena = 1'b0;
    spike_in = 8'hFF; tick = 1'b1; step();
    spike_in = '0; tick = 1'b0; step(); step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0 || ts_done !== 1'b0) begin bad++;
      $display("FAIL ena_ignore: got v=%b b=%b t=%b want 0 0 0", aer_valid, busy, ts_done); end
    ena = 1'b1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    spike_in = 8'hFF; step(); spike_in = '0;
    step();
    total++; if (aer_valid !== 1'b1 || aer_addr !== 3'd0) begin bad++;
      $display("FAIL arst_pre: got v=%b a=%0d want v=1 a=0", aer_valid, aer_addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({aer_valid, busy, ts_done, aer_addr} !== 6'b0) begin bad++;
      $display("FAIL arst_immediate: got v=%b b=%b t=%b a=%0d want all zero", aer_valid, busy, ts_done, aer_addr); end
    #1 rst_n = 1'b1;
    step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL arst_stale1: got v=%b b=%b want 0 0", aer_valid, busy); end
    step();
    total++; if (aer_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL arst_stale2: got v=%b b=%b want 0 0", aer_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_single();
    test_backpressure();
    test_collision();
    test_timestep();
    test_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
